// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS spectrum analysis stage.
package fas_pkg;

  localparam int DW     = 16;
  localparam int NPT    = 16;
  localparam int FREQ_W = 4;
  localparam int MAG_W  = 32;

  // One FFT bin: real part in the upper half, imaginary part in the lower half.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/fas_mag_sq.sv
// Squared magnitude of one complex bin: re*re + im*im, unsigned.
// Each square is at most 2^30, so the sum is at most 2^31 and never wraps.
module fas_mag_sq
  import fas_pkg::*;
(
  input  cplx_t             sample_i,
  output logic [MAG_W-1:0]  mag_o
);

  logic signed [MAG_W-1:0] re_w;
  logic signed [MAG_W-1:0] im_w;
  logic        [MAG_W-1:0] re_sq;
  logic        [MAG_W-1:0] im_sq;

  // Sign-extend before multiplying so the product is a true signed square.
  assign re_w  = MAG_W'(sample_i.re);
  assign im_w  = MAG_W'(sample_i.im);
  assign re_sq = MAG_W'(re_w * re_w);
  assign im_sq = MAG_W'(im_w * im_w);
  assign mag_o = re_sq + im_sq;

endmodule

// File: rtl/fft_peak_detector.sv
// Finds the largest-magnitude bin of each 16-point spectrum, one bin per cycle.
//
//   state | meaning
//   IDLE  | waiting for fft_valid; pending buffer is empty
//   SCAN  | evaluating frame_buf[idx]; a new frame may be parked in pending
module fft_peak_detector
  import fas_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,
  input  logic [2*DW-1:0]   fft_d1,
  input  logic [2*DW-1:0]   fft_d2,
  input  logic [2*DW-1:0]   fft_d3,
  input  logic [2*DW-1:0]   fft_d4,
  input  logic [2*DW-1:0]   fft_d5,
  input  logic [2*DW-1:0]   fft_d6,
  input  logic [2*DW-1:0]   fft_d7,
  input  logic [2*DW-1:0]   fft_d8,
  input  logic [2*DW-1:0]   fft_d9,
  input  logic [2*DW-1:0]   fft_d10,
  input  logic [2*DW-1:0]   fft_d11,
  input  logic [2*DW-1:0]   fft_d12,
  input  logic [2*DW-1:0]   fft_d13,
  input  logic [2*DW-1:0]   fft_d14,
  input  logic [2*DW-1:0]   fft_d15,
  output logic              done,
  output logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic              overflow
);

  state_e              state_q, state_d;
  cplx_t               bus_w    [NPT];
  cplx_t               frame_q  [NPT];
  cplx_t               pend_q   [NPT];
  logic                pend_v_q;
  logic [FREQ_W-1:0]   idx_q;
  logic [MAG_W-1:0]    max_q;
  logic [FREQ_W-1:0]   arg_q;
  logic [FREQ_W-1:0]   freq_q;
  logic                done_q;
  logic                ovf_q;

  logic [MAG_W-1:0]    mag_w;
  logic                better_w;
  logic                last_w;
  logic [FREQ_W-1:0]   arg_fin_w;
  logic                load_bus, load_pend, cap_pend, drop;

  assign bus_w[0]  = cplx_t'(fft_d0);
  assign bus_w[1]  = cplx_t'(fft_d1);
  assign bus_w[2]  = cplx_t'(fft_d2);
  assign bus_w[3]  = cplx_t'(fft_d3);
  assign bus_w[4]  = cplx_t'(fft_d4);
  assign bus_w[5]  = cplx_t'(fft_d5);
  assign bus_w[6]  = cplx_t'(fft_d6);
  assign bus_w[7]  = cplx_t'(fft_d7);
  assign bus_w[8]  = cplx_t'(fft_d8);
  assign bus_w[9]  = cplx_t'(fft_d9);
  assign bus_w[10] = cplx_t'(fft_d10);
  assign bus_w[11] = cplx_t'(fft_d11);
  assign bus_w[12] = cplx_t'(fft_d12);
  assign bus_w[13] = cplx_t'(fft_d13);
  assign bus_w[14] = cplx_t'(fft_d14);
  assign bus_w[15] = cplx_t'(fft_d15);

  fas_mag_sq u_mag_sq (
    .sample_i (frame_q[idx_q]),
    .mag_o    (mag_w)
  );

  // Strict compare keeps the lowest index on ties; an all-zero frame reports bin 0.
  assign better_w  = (mag_w > max_q);
  assign last_w    = (state_q == SCAN) && (idx_q == FREQ_W'(NPT - 1));
  assign arg_fin_w = better_w ? idx_q : arg_q;

  // Next-state and buffer control; pending frames take priority over the bus at frame end.
  always_comb begin
    state_d   = state_q;
    load_bus  = 1'b0;
    load_pend = 1'b0;
    cap_pend  = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fft_valid) begin
          load_bus = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (last_w) begin
          if (pend_v_q) begin
            load_pend = 1'b1;
            cap_pend  = fft_valid;
          end else if (fft_valid) begin
            load_bus = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (fft_valid) begin
          if (pend_v_q) drop = 1'b1;
          else          cap_pend = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Frame and one-deep pending buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPT; k++) begin
        frame_q[k] <= '0;
        pend_q[k]  <= '0;
      end
      pend_v_q <= 1'b0;
    end else begin
      for (int k = 0; k < NPT; k++) begin
        if (load_pend)     frame_q[k] <= pend_q[k];
        else if (load_bus) frame_q[k] <= bus_w[k];
        if (cap_pend)      pend_q[k]  <= bus_w[k];
      end
      if (cap_pend)       pend_v_q <= 1'b1;
      else if (load_pend) pend_v_q <= 1'b0;
    end
  end

  // Scan index, running max/argmax, result and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      max_q  <= '0;
      arg_q  <= '0;
      freq_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= last_w;
      if (last_w) freq_q <= arg_fin_w;
      if (drop)   ovf_q  <= 1'b1;
      if (load_bus || load_pend) begin
        idx_q <= '0;
        max_q <= '0;
        arg_q <= '0;
      end else if (state_q == SCAN) begin
        idx_q <= idx_q + FREQ_W'(1);
        if (better_w) begin
          max_q <= mag_w;
          arg_q <= idx_q;
        end
      end else begin
        idx_q <= '0;
      end
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign busy     = (state_q == SCAN);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench: stimulus pushes expected {freq, done cycle}; a monitor pops on done.
module tb_fft_peak_detector;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] bus [16];
  logic        done;
  logic [3:0]  freq;
  logic        busy;
  logic        overflow;

  typedef struct {
    logic [3:0] f;
    int         c;
  } exp_t;

  exp_t exp_q [$];
  int   cyc;
  int   tests;
  int   fails;

  fft_peak_detector dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(bus[0]),   .fft_d1(bus[1]),   .fft_d2(bus[2]),   .fft_d3(bus[3]),
    .fft_d4(bus[4]),   .fft_d5(bus[5]),   .fft_d6(bus[6]),   .fft_d7(bus[7]),
    .fft_d8(bus[8]),   .fft_d9(bus[9]),   .fft_d10(bus[10]), .fft_d11(bus[11]),
    .fft_d12(bus[12]), .fft_d13(bus[13]), .fft_d14(bus[14]), .fft_d15(bus[15]),
    .done(done), .freq(freq), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got freq 0x%0h with no frame outstanding (cycle %0d)", freq, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_freq", 32'(freq), 32'(e.f));
        check("done_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    for (int k = 0; k < 16; k++) bus[k] = 32'h0;
  endtask

  // Drive one valid cycle; the frame is sampled on the next edge, done 16 edges later.
  task automatic pulse(input logic [3:0] f, input bit expect_done, input int done_cyc);
    if (expect_done) begin
      exp_t e;
      e.f = f;
      e.c = done_cyc;
      exp_q.push_back(e);
    end
    fft_valid = 1'b1;
    step();
    fft_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int p;
    cyc = 0; tests = 0; fails = 0;
    fft_valid = 1'b0;
    clear_bus();
    rst = 1'b0;
    repeat (3) step();
    check("rst_done", 32'(done), 32'h0);
    check("rst_freq", 32'(freq), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b1;
    step();

    // 1: single nonzero bin 0
    clear_bus();
    bus[0] = {16'h0400, 16'h0000};
    pulse(4'd0, 1'b1, cyc + 17);
    check("busy_after_valid", 32'(busy), 32'h1);
    repeat (20) step();
    check("busy_idle_again", 32'(busy), 32'h0);

    // 2: negative imaginary square beats smaller positive real
    clear_bus();
    bus[9] = {16'h0000, 16'hFD00};
    bus[2] = {16'h0200, 16'h0000};
    pulse(4'd9, 1'b1, cyc + 17);
    repeat (20) step();

    // 3a: tie between bins 3 and 12 resolves to 3
    clear_bus();
    bus[3]  = {16'h0100, 16'h0100};
    bus[12] = {16'h0100, 16'h0100};
    bus[7]  = {16'h0080, 16'h0000};
    pulse(4'd3, 1'b1, cyc + 17);
    repeat (20) step();

    // 3b: most negative values give 0x80000000 without wrapping
    clear_bus();
    bus[5] = {16'h8000, 16'h8000};
    bus[0] = {16'h7FFF, 16'h7FFF};
    pulse(4'd5, 1'b1, cyc + 17);
    repeat (20) step();

    // 3c: peak in the last bin
    clear_bus();
    bus[15] = {16'h0001, 16'h0000};
    pulse(4'd15, 1'b1, cyc + 17);
    repeat (20) step();

    // 3d: all-zero frame reports bin 0
    clear_bus();
    pulse(4'd0, 1'b1, cyc + 17);
    repeat (20) step();

    // 5: back-to-back frames every 16 cycles
    for (int i = 0; i < 64; i++) begin
      p = (i * 7) % 16;
      clear_bus();
      bus[p]            = {16'h0000, 16'hFE00};
      bus[(p + 3) % 16] = {16'h01FF, 16'h0000};
      pulse(4'(p), 1'b1, cyc + 17);
      repeat (15) step();
      check("stream_busy", 32'(busy), 32'h1);
    end
    repeat (4) step();
    check("stream_overflow", 32'(overflow), 32'h0);
    repeat (20) step();

    // 4: second frame parks in pending, third is dropped
    t0 = cyc;
    clear_bus();
    bus[4] = {16'h0300, 16'h0000};
    pulse(4'd4, 1'b1, t0 + 17);
    repeat (3) step();
    clear_bus();
    bus[10] = {16'h0000, 16'h0300};
    pulse(4'd10, 1'b1, t0 + 33);
    repeat (3) step();
    clear_bus();
    bus[1] = {16'h0500, 16'h0000};
    pulse(4'd1, 1'b0, 0);
    step();
    check("drop_overflow", 32'(overflow), 32'h1);
    repeat (40) step();
    check("overflow_sticky", 32'(overflow), 32'h1);

    // 6: reset mid-scan aborts without a done pulse
    clear_bus();
    bus[6] = {16'h0200, 16'h0200};
    pulse(4'd6, 1'b0, 0);
    repeat (6) step();
    rst = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'h0);
    check("abort_freq", 32'(freq), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_overflow", 32'(overflow), 32'h0);
    step();
    rst = 1'b1;
    repeat (25) step();
    clear_bus();
    bus[11] = {16'hFF00, 16'h0000};
    pulse(4'd11, 1'b1, cyc + 17);
    repeat (20) step();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
